// File: rtl/prog_check_pkg.sv
// Shared types and constants for the program checkpoint monitor.
package prog_check_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_RUN,
      S_SETTLE,
      S_CHECK,
      S_DONE,
      S_TIMEOUT
   } state_t;

   localparam int DEF_WDOG_LIMIT = 255;
   localparam int DEF_SETTLE_CYC = 1;
   localparam int NUM_CHK_MIN    = 1;
   localparam int NUM_CHK_MAX    = 16;

endpackage

// File: rtl/prog_check_table.sv
// Checkpoint table: NUM_CHK entries of {pc threshold, expected data}, cleared on reset.
module prog_check_table
   import prog_check_pkg::*;
#(
   parameter int NUM_CHK = 2,
   parameter int IDX_W   = 4,
   parameter int PC_W    = 64,
   parameter int DATA_W  = 64
) (
   input  logic              CLK,
   input  logic              reset,
   input  logic              we,
   input  logic [IDX_W-1:0]  wr_idx,
   input  logic [PC_W-1:0]   wr_pc,
   input  logic [DATA_W-1:0] wr_exp,
   input  logic [IDX_W-1:0]  rd_idx,
   output logic [PC_W-1:0]   rd_pc,
   output logic [DATA_W-1:0] rd_exp
);

   logic [PC_W-1:0]   pc_q  [NUM_CHK];
   logic [DATA_W-1:0] exp_q [NUM_CHK];

   always_ff @(posedge CLK or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NUM_CHK; i++) begin
            pc_q[i]  <= '0;
            exp_q[i] <= '0;
         end
      end else if (we) begin
         for (int i = 0; i < NUM_CHK; i++) begin
            if (wr_idx == IDX_W'(i)) begin
               pc_q[i]  <= wr_pc;
               exp_q[i] <= wr_exp;
            end
         end
      end
   end

   // Mux-style read keeps the index width independent of the entry count.
   always_comb begin
      rd_pc  = '0;
      rd_exp = '0;
      for (int i = 0; i < NUM_CHK; i++) begin
         if (rd_idx == IDX_W'(i)) begin
            rd_pc  = pc_q[i];
            rd_exp = exp_q[i];
         end
      end
   end

endmodule

// File: rtl/prog_check_monitor.sv
// Walks a checkpoint table against the processor PC/data and reports pass/fail.
//   state     | meaning
//   S_IDLE    | waiting for start
//   S_RUN     | waiting for currentpc >= threshold of entry idx
//   S_SETTLE  | letting dmemout settle for SETTLE_CYC cycles
//   S_CHECK   | sample dmemout and score entry idx
//   S_DONE    | all entries scored (sticky until start)
//   S_TIMEOUT | watchdog expired (sticky until start)
module prog_check_monitor
   import prog_check_pkg::*;
#(
   parameter int PC_W       = 64,
   parameter int DATA_W     = 64,
   parameter int NUM_CHK    = 2,
   parameter int IDX_W      = 4,
   parameter int SETTLE_CYC = DEF_SETTLE_CYC,
   parameter int WDOG_W     = 16,
   parameter int WDOG_LIMIT = DEF_WDOG_LIMIT
) (
   input  logic              CLK,
   input  logic              reset,
   input  logic              start,
   input  logic              cfg_we,
   input  logic [IDX_W-1:0]  cfg_idx,
   input  logic [PC_W-1:0]   cfg_pc,
   input  logic [DATA_W-1:0] cfg_exp,
   input  logic [PC_W-1:0]   currentpc,
   input  logic [DATA_W-1:0] dmemout,
   output logic              busy,
   output logic              done,
   output logic              timeout,
   output logic              all_passed,
   output logic [IDX_W:0]    passed_cnt,
   output logic              chk_valid,
   output logic              chk_pass,
   output logic [IDX_W-1:0]  chk_idx,
   output logic [DATA_W-1:0] chk_actual
);

   localparam logic [IDX_W-1:0]  LAST_IDX    = IDX_W'(NUM_CHK - 1);
   localparam logic [IDX_W:0]    CHK_TOTAL   = (IDX_W + 1)'(NUM_CHK);
   localparam logic [WDOG_W-1:0] WDOG_END    = WDOG_W'(WDOG_LIMIT);
   localparam logic [7:0]        SETTLE_LOAD = 8'(SETTLE_CYC);

   state_t            state;
   logic [IDX_W-1:0]  idx;
   logic [7:0]        settle_cnt;
   logic [WDOG_W-1:0] wdog;
   logic [WDOG_W-1:0] wdog_inc;
   logic [PC_W-1:0]   tbl_pc;
   logic [DATA_W-1:0] tbl_exp;
   logic              wr_en;
   logic              expire;
   logic              pc_hit;
   logic              exp_hit;

   assign busy       = (state == S_RUN) || (state == S_SETTLE) || (state == S_CHECK);
   assign wr_en      = cfg_we && !busy && ({1'b0, cfg_idx} < CHK_TOTAL);
   assign wdog_inc   = (&wdog) ? wdog : wdog + WDOG_W'(1);
   assign expire     = busy && (wdog_inc >= WDOG_END);
   assign pc_hit     = currentpc >= tbl_pc;
   assign exp_hit    = dmemout == tbl_exp;
   assign all_passed = done && (passed_cnt == CHK_TOTAL);

   prog_check_table #(
      .NUM_CHK (NUM_CHK),
      .IDX_W   (IDX_W),
      .PC_W    (PC_W),
      .DATA_W  (DATA_W)
   ) u_table (
      .CLK     (CLK),
      .reset   (reset),
      .we      (wr_en),
      .wr_idx  (cfg_idx),
      .wr_pc   (cfg_pc),
      .wr_exp  (cfg_exp),
      .rd_idx  (idx),
      .rd_pc   (tbl_pc),
      .rd_exp  (tbl_exp)
   );

   always_ff @(posedge CLK or posedge reset) begin
      if (reset) begin
         state      <= S_IDLE;
         idx        <= '0;
         settle_cnt <= '0;
         wdog       <= '0;
         done       <= 1'b0;
         timeout    <= 1'b0;
         passed_cnt <= '0;
         chk_valid  <= 1'b0;
         chk_pass   <= 1'b0;
         chk_idx    <= '0;
         chk_actual <= '0;
      end else begin
         chk_valid <= 1'b0;
         if (busy) begin
            wdog <= wdog_inc;
         end
         // Expiry overrides whatever the current state would have done, CHECK included.
         if (expire) begin
            state   <= S_TIMEOUT;
            timeout <= 1'b1;
         end else begin
            case (state)
               S_IDLE, S_DONE, S_TIMEOUT: begin
                  if (start) begin
                     idx        <= '0;
                     passed_cnt <= '0;
                     wdog       <= '0;
                     chk_actual <= '0;
                     done       <= 1'b0;
                     timeout    <= 1'b0;
                     state      <= S_RUN;
                  end
               end
               S_RUN: begin
                  if (pc_hit) begin
                     settle_cnt <= SETTLE_LOAD;
                     state      <= S_SETTLE;
                  end
               end
               S_SETTLE: begin
                  settle_cnt <= settle_cnt - 8'd1;
                  if (settle_cnt <= 8'd1) begin
                     state <= S_CHECK;
                  end
               end
               S_CHECK: begin
                  chk_actual <= dmemout;
                  chk_valid  <= 1'b1;
                  chk_idx    <= idx;
                  chk_pass   <= exp_hit;
                  if (exp_hit) begin
                     passed_cnt <= passed_cnt + (IDX_W + 1)'(1);
                  end
                  if (idx == LAST_IDX) begin
                     done  <= 1'b1;
                     state <= S_DONE;
                  end else begin
                     idx   <= idx + IDX_W'(1);
                     state <= S_RUN;
                  end
               end
               default: state <= S_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_prog_check_monitor.sv
// Bench for prog_check_monitor: two instances (settle 1 and settle 3) share stimulus.
module tb_prog_check_monitor;

   localparam int NC = 2;
   localparam int IW = 4;

   logic          CLK = 1'b0;
   logic          reset = 1'b0;
   logic          start = 1'b0;
   logic          cfg_we = 1'b0;
   logic [IW-1:0] cfg_idx = '0;
   logic [63:0]   cfg_pc = '0;
   logic [63:0]   cfg_exp = '0;
   logic [63:0]   currentpc = '0;
   logic [63:0]   dmemout = '0;

   logic          busy_w [2];
   logic          done_w [2];
   logic          timeout_w [2];
   logic          all_passed_w [2];
   logic [IW:0]   passed_cnt_w [2];
   logic          chk_valid_w [2];
   logic          chk_pass_w [2];
   logic [IW-1:0] chk_idx_w [2];
   logic [63:0]   chk_actual_w [2];

   int total = 0;
   int bad = 0;

   // Scenario description consumed by run_check.
   logic [63:0] m_thr [2];
   logic [63:0] m_exp [2];
   logic [63:0] m_bad [2];
   logic        m_pass [2];
   bit          m_frozen, m_hold, m_noise, m_do_reset, m_load;

   always #5 CLK = ~CLK;

   prog_check_monitor #(
      .PC_W(64), .DATA_W(64), .NUM_CHK(NC), .IDX_W(IW),
      .SETTLE_CYC(1), .WDOG_W(16), .WDOG_LIMIT(255)
   ) dut_s1 (
      .CLK(CLK), .reset(reset), .start(start), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
      .cfg_pc(cfg_pc), .cfg_exp(cfg_exp), .currentpc(currentpc), .dmemout(dmemout),
      .busy(busy_w[0]), .done(done_w[0]), .timeout(timeout_w[0]),
      .all_passed(all_passed_w[0]), .passed_cnt(passed_cnt_w[0]),
      .chk_valid(chk_valid_w[0]), .chk_pass(chk_pass_w[0]),
      .chk_idx(chk_idx_w[0]), .chk_actual(chk_actual_w[0])
   );

   prog_check_monitor #(
      .PC_W(64), .DATA_W(64), .NUM_CHK(NC), .IDX_W(IW),
      .SETTLE_CYC(3), .WDOG_W(16), .WDOG_LIMIT(255)
   ) dut_s3 (
      .CLK(CLK), .reset(reset), .start(start), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
      .cfg_pc(cfg_pc), .cfg_exp(cfg_exp), .currentpc(currentpc), .dmemout(dmemout),
      .busy(busy_w[1]), .done(done_w[1]), .timeout(timeout_w[1]),
      .all_passed(all_passed_w[1]), .passed_cnt(passed_cnt_w[1]),
      .chk_valid(chk_valid_w[1]), .chk_pass(chk_pass_w[1]),
      .chk_idx(chk_idx_w[1]), .chk_actual(chk_actual_w[1])
   );

   task automatic step;
      @(posedge CLK);
      #1;
   endtask

   task automatic set_basic;
      m_thr[0] = 64'h34;  m_exp[0] = 64'hF;
      m_thr[1] = 64'h5C;  m_exp[1] = 64'h1234_5678_9ABC_DEF0;
      m_pass[0] = 1'b1;   m_pass[1] = 1'b1;
      m_bad[0] = m_exp[0] ^ 64'h1;
      m_bad[1] = m_exp[1] ^ 64'h1;
      m_frozen = 0; m_hold = 0; m_noise = 0; m_do_reset = 1; m_load = 1;
   endtask

   // Model: entry k is hit in the first cycle >= its RUN start with pc >= threshold;
   // scored in cycle hit+S+1, reported in hit+S+2; the watchdog fires at the end of
   // cycle 254 (255th busy cycle), so a CHECK in cycle >= 254 never reports.
   task automatic run_check(input int u, input string nm);
      int s, r, npass, endc, first_to, first_done, want_to, want_done, k_hit;
      int h [2];
      int chk [2];
      bit exp_to, want_valid;
      logic [63:0] drv, want_act;
      s = (u == 1) ? 3 : 1;
      r = 0;
      for (int k = 0; k < 2; k++) begin
         if (m_frozen) h[k] = (m_thr[k] > 64'h10) ? 100000 : r;
         else begin
            h[k] = (int'(m_thr[k]) + 3) / 4;
            if (h[k] < r) h[k] = r;
         end
         chk[k] = h[k] + s + 1;
         r = chk[k] + 1;
      end
      exp_to = (chk[1] >= 254);
      endc = exp_to ? 256 : chk[1] + 2;
      npass = 0;
      for (int k = 0; k < 2; k++) if (chk[k] <= 253 && m_pass[k]) npass++;

      if (m_do_reset) begin
         reset = 1'b1; step; step; reset = 1'b0;
      end
      if (m_load) begin
         for (int k = 0; k < 2; k++) begin
            cfg_we = 1'b1; cfg_idx = IW'(k); cfg_pc = m_thr[k]; cfg_exp = m_exp[k];
            step;
         end
         if (m_noise) begin
            cfg_we = 1'b1; cfg_idx = IW'(NC); cfg_pc = '0; cfg_exp = '0;
            step;
         end
      end
      cfg_we = 1'b0; start = 1'b1;
      step;
      start = 1'b0;
      first_to = -1;
      first_done = -1;
      for (int c = 0; c <= endc; c++) begin
         currentpc = m_frozen ? 64'h10 : 64'(4 * c);
         drv = m_hold ? 64'h0 : {$urandom, $urandom};
         for (int k = 0; k < 2; k++)
            if (m_hold ? (c == chk[k] - 1 || c == chk[k]) : (c == chk[k]))
               drv = m_pass[k] ? m_exp[k] : m_bad[k];
         dmemout = drv;
         cfg_we = 1'b0;
         start = 1'b0;
         if (m_noise && c == 1) begin
            cfg_we = 1'b1; cfg_idx = '0; cfg_pc = '0; cfg_exp = 64'hBAD;
         end
         if (m_noise && c == chk[0] + 2 && chk[0] + 2 < 254) start = 1'b1;
         @(negedge CLK);
         if (c == 0) begin
            total++;
            if ({busy_w[u], done_w[u], timeout_w[u], passed_cnt_w[u], chk_actual_w[u]} !==
                {1'b1, 1'b0, 1'b0, 5'd0, 64'd0}) begin
               bad++;
               $display("FAIL %s first_run_cycle: got busy=%b done=%b to=%b cnt=%0d act=%h want 1 0 0 0 0",
                        nm, busy_w[u], done_w[u], timeout_w[u], passed_cnt_w[u], chk_actual_w[u]);
            end
         end
         k_hit = -1;
         for (int k = 0; k < 2; k++) if (chk[k] <= 253 && c == chk[k] + 1) k_hit = k;
         want_valid = (k_hit >= 0);
         total++;
         if (chk_valid_w[u] !== want_valid) begin
            bad++;
            $display("FAIL %s chk_valid cycle %0d: got %b want %b", nm, c, chk_valid_w[u], want_valid);
         end else if (want_valid) begin
            want_act = m_pass[k_hit] ? m_exp[k_hit] : m_bad[k_hit];
            total++;
            if ({chk_pass_w[u], chk_idx_w[u], chk_actual_w[u]} !== {m_pass[k_hit], IW'(k_hit), want_act}) begin
               bad++;
               $display("FAIL %s result cycle %0d: got pass=%b idx=%0d act=%h want pass=%b idx=%0d act=%h",
                        nm, c, chk_pass_w[u], chk_idx_w[u], chk_actual_w[u], m_pass[k_hit], k_hit, want_act);
            end
         end
         if (timeout_w[u] === 1'b1 && first_to < 0) first_to = c;
         if (done_w[u] === 1'b1 && first_done < 0) first_done = c;
         step;
      end
      cfg_we = 1'b0;
      start = 1'b0;
      want_to = exp_to ? 255 : -1;
      want_done = exp_to ? -1 : chk[1] + 1;
      total++;
      if (first_to != want_to) begin
         bad++;
         $display("FAIL %s timeout_cycle: got %0d want %0d", nm, first_to, want_to);
      end
      total++;
      if (first_done != want_done) begin
         bad++;
         $display("FAIL %s done_cycle: got %0d want %0d", nm, first_done, want_done);
      end
      @(negedge CLK);
      total++;
      if ({busy_w[u], done_w[u], timeout_w[u], all_passed_w[u], passed_cnt_w[u]} !==
          {1'b0, !exp_to, exp_to, (!exp_to && npass == 2), 5'(npass)}) begin
         bad++;
         $display("FAIL %s final: got busy=%b done=%b to=%b all=%b cnt=%0d want 0 %b %b %b %0d",
                  nm, busy_w[u], done_w[u], timeout_w[u], all_passed_w[u], passed_cnt_w[u],
                  !exp_to, exp_to, (!exp_to && npass == 2), npass);
      end
   endtask

   task automatic test_reset;
      logic [78:0] v;
      reset = 1'b1;
      step; step;
      for (int u = 0; u < 2; u++) begin
         v = {busy_w[u], done_w[u], timeout_w[u], all_passed_w[u], passed_cnt_w[u],
              chk_valid_w[u], chk_pass_w[u], chk_idx_w[u], chk_actual_w[u]};
         total++;
         if (v !== '0) begin
            bad++;
            $display("FAIL reset_outputs u%0d: got %h want 0", u, v);
         end
      end
      reset = 1'b0;
   endtask

   task automatic test_basic;
      set_basic;
      run_check(0, "basic");
   endtask

   task automatic test_mismatch;
      set_basic;
      m_pass[0] = 1'b0;
      m_bad[0] = 64'hE;
      run_check(0, "mismatch");
   endtask

   task automatic test_watchdog;
      set_basic;
      m_frozen = 1;
      run_check(0, "watchdog");
   endtask

   task automatic test_wdog_boundary;
      set_basic;
      m_thr[1] = 64'd1004;
      run_check(0, "wdog_check_253");
      set_basic;
      m_thr[1] = 64'd1008;
      run_check(0, "wdog_check_254");
   endtask

   task automatic test_settle;
      set_basic;
      m_thr[0] = 64'h8;   m_exp[0] = 64'hF;
      m_thr[1] = 64'h10;  m_exp[1] = 64'h55;
      m_hold = 1;
      run_check(1, "settle3");
   endtask

   task automatic test_ignored;
      set_basic;
      m_noise = 1;
      run_check(0, "ignored_s1");
      set_basic;
      m_noise = 1;
      run_check(1, "ignored_s3");
   endtask

   task automatic test_back_to_back;
      set_basic;
      m_do_reset = 0;
      run_check(0, "restart_from_timeout");
      set_basic;
      m_do_reset = 0;
      m_thr[0] = 64'h0;
      m_exp[1] = {$urandom, $urandom};
      m_bad[1] = m_exp[1] ^ 64'h8000;
      m_pass[1] = 1'b0;
      run_check(0, "restart_from_done");
   endtask

   task automatic test_reset_mid_run;
      logic [78:0] v;
      set_basic;
      reset = 1'b1; step; step; reset = 1'b0;
      for (int k = 0; k < 2; k++) begin
         cfg_we = 1'b1; cfg_idx = IW'(k); cfg_pc = m_thr[k]; cfg_exp = m_exp[k];
         step;
      end
      cfg_we = 1'b0; start = 1'b1;
      step;
      start = 1'b0;
      for (int c = 0; c <= 24; c++) begin
         currentpc = 64'(4 * c);
         dmemout = (c == 15 || c == 17) ? 64'hF : 64'h0;
         @(negedge CLK);
         if (c < 24) step;
      end
      for (int u = 0; u < 2; u++) begin
         total++;
         if ({busy_w[u], passed_cnt_w[u], chk_actual_w[u]} !== {1'b1, 5'd1, 64'hF}) begin
            bad++;
            $display("FAIL pre_reset u%0d: got busy=%b cnt=%0d act=%h want 1 1 f",
                     u, busy_w[u], passed_cnt_w[u], chk_actual_w[u]);
         end
      end
      reset = 1'b1;
      #1;
      for (int u = 0; u < 2; u++) begin
         v = {busy_w[u], done_w[u], timeout_w[u], all_passed_w[u], passed_cnt_w[u],
              chk_valid_w[u], chk_pass_w[u], chk_idx_w[u], chk_actual_w[u]};
         total++;
         if (v !== '0) begin
            bad++;
            $display("FAIL mid_run_reset u%0d: got %h want 0", u, v);
         end
      end
      step;
      reset = 1'b0;
      // A cleared table means threshold 0 / expected 0 for both entries.
      set_basic;
      m_thr[0] = '0; m_exp[0] = '0; m_bad[0] = 64'h1;
      m_thr[1] = '0; m_exp[1] = '0; m_bad[1] = 64'h1;
      m_do_reset = 0; m_load = 0;
      run_check(0, "cleared_table");
      set_basic;
      run_check(0, "after_reset");
   endtask

   task automatic test_random;
      for (int i = 0; i < 8; i++) begin
         set_basic;
         m_thr[0] = 64'($urandom_range(0, 120));
         m_thr[1] = 64'($urandom_range(0, 1100));
         for (int k = 0; k < 2; k++) begin
            m_exp[k]  = {$urandom, $urandom};
            m_pass[k] = 1'($urandom_range(0, 1));
            m_bad[k]  = m_exp[k] ^ (64'h1 << $urandom_range(0, 63));
         end
         m_noise = bit'($urandom_range(0, 1));
         run_check(int'($urandom_range(0, 1)), "random");
      end
   endtask

   initial begin
      test_reset;
      test_basic;
      test_mismatch;
      test_settle;
      test_ignored;
      test_watchdog;
      test_back_to_back;
      test_wdog_boundary;
      test_reset_mid_run;
      test_random;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
